// File: rtl/interval_sync_if.sv
// interval_sync_if: pps, configuration and packet_counter-facing outputs of interval_sync; pps_err present with INTERVAL_SYNC_PPS_ERR_EN
interface interval_sync_if #(
    parameter int LEN_W = 32,
    parameter int PER_W = 16
);
    logic             pps;
    logic [LEN_W-1:0] interval_len;
    logic [15:0]      n_intervals;
    logic [PER_W-1:0] packet_period;
    logic [15:0]      packets_per_int;
    logic [15:0]      Numb_inter;
    logic             cnt_clr;
    logic             ev;
    logic [7:0]       n_ch;
    logic             busy;
`ifdef INTERVAL_SYNC_PPS_ERR_EN
    logic             pps_err;
    modport master (output pps, interval_len, n_intervals, packet_period, packets_per_int,
                    input Numb_inter, cnt_clr, ev, n_ch, busy, pps_err);
    modport slave  (input pps, interval_len, n_intervals, packet_period, packets_per_int,
                    output Numb_inter, cnt_clr, ev, n_ch, busy, pps_err);
`else
    modport master (output pps, interval_len, n_intervals, packet_period, packets_per_int,
                    input Numb_inter, cnt_clr, ev, n_ch, busy);
    modport slave  (input pps, interval_len, n_intervals, packet_period, packets_per_int,
                    output Numb_inter, cnt_clr, ev, n_ch, busy);
`endif
endinterface

// File: rtl/interval_sync.sv
// interval_sync: splits each pps second into intervals with clear pulses and packet strobes; optional pps_err via INTERVAL_SYNC_PPS_ERR_EN
module interval_sync #(
    parameter int LEN_W = 32,
    parameter int PER_W = 16
) (
    input logic            clk,
    input logic            clr,
    interval_sync_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state, state_nx;
    logic             pps_d, rise, int_end, last_int, fire;
    logic [LEN_W-1:0] len_s, int_timer;
    logic [PER_W-1:0] per_s, pkt_timer;
    logic [15:0]      nint_s, ppi_s, pkt_idx;

    // edge detect, interval end, strobe decision and next state
    always_comb begin
        rise     = bus.pps & ~pps_d;
        int_end  = (state == RUN) && (int_timer == len_s - LEN_W'(1));
        last_int = bus.Numb_inter >= nint_s - 16'd1;
        fire     = (state == RUN) && !int_end && (pkt_timer == '0) && (pkt_idx < ppi_s);
        state_nx = rise ? RUN : (int_end && last_int) ? HOLD : state;
    end

    // state register
    always_ff @(posedge clk) begin
        state <= clr ? IDLE : state_nx;
    end

    // timers, shadowed config and registered outputs; a rise always restarts the second
    always_ff @(posedge clk) begin
        if (clr) begin
            pps_d          <= 1'b0;
            len_s          <= '0;
            per_s          <= '0;
            nint_s         <= '0;
            ppi_s          <= '0;
            int_timer      <= '0;
            pkt_timer      <= '0;
            pkt_idx        <= '0;
            bus.Numb_inter <= '0;
            bus.cnt_clr    <= 1'b0;
            bus.ev         <= 1'b0;
            bus.n_ch       <= '0;
        end else begin
            pps_d       <= bus.pps;
            bus.cnt_clr <= rise || (int_end && !last_int);
            bus.ev      <= fire && !rise;
            if (rise) begin
                len_s          <= (bus.interval_len < LEN_W'(2)) ? LEN_W'(2) : bus.interval_len;
                per_s          <= (bus.packet_period == '0) ? PER_W'(1) : bus.packet_period;
                nint_s         <= (bus.n_intervals == '0) ? 16'd1 : bus.n_intervals;
                ppi_s          <= bus.packets_per_int;
                int_timer      <= '0;
                pkt_timer      <= '0;
                pkt_idx        <= '0;
                bus.Numb_inter <= '0;
            end else if (state == RUN) begin
                if (int_end) begin
                    if (!last_int) begin
                        int_timer      <= '0;
                        pkt_timer      <= '0;
                        pkt_idx        <= '0;
                        bus.Numb_inter <= bus.Numb_inter + 16'd1;
                    end
                end else begin
                    int_timer <= int_timer + LEN_W'(1);
                    if (fire) begin
                        pkt_timer <= per_s - PER_W'(1);
                        pkt_idx   <= pkt_idx + 16'd1;
                        bus.n_ch  <= {7'd0, pkt_idx[0]};
                    end else if (pkt_timer != '0) begin
                        pkt_timer <= pkt_timer - PER_W'(1);
                    end
                end
            end
        end
    end

    assign bus.busy = (state == RUN);

`ifdef INTERVAL_SYNC_PPS_ERR_EN
    logic [LEN_W:0] hold_timer;

    // sticky error on an early pps or on a pps missing for more than twice the interval length
    always_ff @(posedge clk) begin
        if (clr) begin
            hold_timer  <= '0;
            bus.pps_err <= 1'b0;
        end else begin
            hold_timer <= (state != HOLD || rise) ? '0 :
                          (hold_timer == {len_s, 1'b0}) ? hold_timer : hold_timer + (LEN_W+1)'(1);
            if ((rise && state == RUN) || (state == HOLD && !rise && hold_timer == {len_s, 1'b0}))
                bus.pps_err <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_interval_sync.sv
// tb_interval_sync: directed bench for interval_sync
module tb_interval_sync;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    interval_sync_if #(.LEN_W(32), .PER_W(16)) bus ();
    interval_sync #(.LEN_W(32), .PER_W(16)) dut (.clk(clk), .clr(clr), .bus(bus));

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet();
        check("cnt_clr_quiet", int'(bus.cnt_clr), 0);
        check("ev_quiet", int'(bus.ev), 0);
        check("busy_quiet", int'(bus.busy), 0);
    endtask

    // raises pps now (cycle T), holds it for `hold` cycles, checks `steps` cycles against the closed-form timeline
    task automatic rise_and_run(input int len, input int nint, input int per, input int ppi,
                                input int steps, input int hold);
        int  el, ep, en, t, k;
        bit  run, e;
        el = (len < 2) ? 2 : len;
        ep = (per == 0) ? 1 : per;
        en = (nint == 0) ? 1 : nint;
        bus.interval_len    = 32'(len);
        bus.n_intervals     = 16'(nint);
        bus.packet_period   = 16'(per);
        bus.packets_per_int = 16'(ppi);
        bus.pps = 1'b1;
        for (int s = 1; s <= steps; s++) begin
            step();
            if (s == hold) bus.pps = 1'b0;
            if (s == 1) begin
                bus.interval_len    = 32'd7;
                bus.n_intervals     = 16'd9;
                bus.packet_period   = 16'd3;
                bus.packets_per_int = 16'd1;
            end
            run = s <= en * el;
            t   = (s - 1) % el;
            k   = (t - 1) / ep;
            e   = run && t >= 1 && ((t - 1) % ep == 0) && k < ppi;
            check("cnt_clr", int'(bus.cnt_clr), int'(run && t == 0));
            check("ev", int'(bus.ev), int'(e));
            check("busy", int'(bus.busy), int'(run));
            check("numb_inter", int'(bus.Numb_inter), run ? (s - 1) / el : en - 1);
            if (e) check("n_ch", int'(bus.n_ch), k % 2);
        end
    endtask

    initial begin
        bus.pps = 1'b0;
        bus.interval_len = '0;
        bus.n_intervals = '0;
        bus.packet_period = '0;
        bus.packets_per_int = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_quiet();
            check("numb_reset", int'(bus.Numb_inter), 0);
            check("n_ch_reset", int'(bus.n_ch), 0);
        end
        clr = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            check_quiet();
            check("numb_idle", int'(bus.Numb_inter), 0);
        end
        rise_and_run(20, 3, 4, 3, 70, 1);
        rise_and_run(10, 2, 4, 5, 25, 1);
`ifdef INTERVAL_SYNC_PPS_ERR_EN
        check("pps_err_clean", int'(bus.pps_err), 0);
`endif
        rise_and_run(20, 3, 4, 3, 30, 1);
        rise_and_run(20, 3, 4, 3, 45, 1);
`ifdef INTERVAL_SYNC_PPS_ERR_EN
        check("pps_err_early", int'(bus.pps_err), 1);
`endif
        rise_and_run(20, 3, 4, 3, 70, 50);
        rise_and_run(20, 3, 4, 3, 15, 1);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check_quiet();
        check("numb_clr", int'(bus.Numb_inter), 0);
        check("n_ch_clr", int'(bus.n_ch), 0);
`ifdef INTERVAL_SYNC_PPS_ERR_EN
        check("pps_err_clr", int'(bus.pps_err), 0);
`endif
        for (int i = 0; i < 30; i++) begin
            step();
            check_quiet();
        end
        rise_and_run(0, 0, 0, 2, 4, 1);
`ifdef INTERVAL_SYNC_PPS_ERR_EN
        check("pps_err_hold_ok", int'(bus.pps_err), 0);
`endif
        for (int i = 0; i < 6; i++) begin
            step();
            check_quiet();
            check("numb_hold", int'(bus.Numb_inter), 0);
        end
`ifdef INTERVAL_SYNC_PPS_ERR_EN
        check("pps_err_missing", int'(bus.pps_err), 1);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/interval_sync.md
Name: interval_sync

Overview:
- Upstream timing stage for packet_counter. Tracks the second mark (pps) and cuts each second into fixed-length intervals.
- Outputs per interval:
  - the interval number Numb_inter
  - a one-cycle counter-clear pulse at every interval start
  - a train of packet strobes ev, with channel select n_ch alternating 0/1
- Outputs wire directly to packet_counter as Numb_inter, clr, ev and n_ch.

Parameters:
- LEN_W, 32, width of the interval-length field (clocks per interval).
- PER_W, 16, width of the packet-period field (clocks between packet strobes).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- clr  in  1  synchronous active-high reset.
- pps  in  1  second mark, already synchronous to clk; level, may stay high for multiple cycles.
- interval_len  in  LEN_W  clocks per interval.
- n_intervals  in  16  intervals per second.
- packet_period  in  PER_W  clocks between consecutive ev.
- packets_per_int  in  16  packet strobes per interval.
- Numb_inter  out  16  current interval number since last pps.
- cnt_clr  out  1  one-cycle clear pulse for packet_counter.
- ev  out  1  one-cycle packet strobe.
- n_ch  out  8  channel of the current ev: 0 or 1.
- busy  out  1  high in RUN state.

Behaviour:
- Reset: clr=1 at a clock edge forces the following.
  - Outputs: Numb_inter=0, cnt_clr=0, ev=0, n_ch=0, busy=0.
  - Internal: state=IDLE, pps edge register=0, all timers=0.
  - clr mid-interval aborts immediately. No ev/cnt_clr until the next pps rise after clr deasserts.
- pps edge:
  - rise = pps & ~pps_d, with pps_d registered.
  - Only the rising edge acts. A level held high gives a single event.
- States:
  - IDLE: wait for rise.
  - RUN: interval generation.
  - HOLD: last interval of the second completed; wait for rise.
- Rise accepted in cycle T, from any state:
  - Shadow-register interval_len, n_intervals, packet_period, packets_per_int. Config changes take effect only at a pps rise.
  - At T+1: state=RUN, Numb_inter=0, int_timer=0, pkt_idx=0, cnt_clr=1 for exactly one cycle.
  - A rise inside RUN restarts the second the same way (resync). The current interval is abandoned.
- Degenerate config, applied to the shadows:
  - interval_len<2 is treated as 2.
  - packet_period=0 is treated as 1.
  - n_intervals=0 is treated as 1.
  - packets_per_int=0 means no ev.
- int_timer:
  - Counts 0..len-1 in RUN; 0 in the cnt_clr cycle.
  - At int_timer==len-1:
    - If Numb_inter<n_int-1: int_timer=0, Numb_inter+1, cnt_clr=1 next cycle.
    - Otherwise: state=HOLD, cnt_clr stays 0, Numb_inter holds its last value.
  - Numb_inter never wraps within a second. At 16-bit max it saturates via the n_int-1 bound.
- ev timing:
  - Registered. ev=1 in the cycle where int_timer == 1 + k*packet_period, for k=0..packets_per_int-1.
  - ev is emitted only while that int_timer value is <= len-1. Strobes that would fall past the interval end are dropped, never carried over.
  - ev never coincides with cnt_clr. First ev is 1 cycle after cnt_clr.
  - n_ch = k[0] (k even → 0, odd → 1), valid only with ev; otherwise holds its last value.
- Multiplication-free implementation:
  - pkt_timer reloads packet_period-1 after each ev.
  - pkt_idx increments per ev and stops at packets_per_int.
- HOLD: ev=0, cnt_clr=0, busy=0.
- Simultaneous events:
  - rise in the same cycle as interval end: rise wins.
  - clr wins over everything.

Optional Feature:
- Macro INTERVAL_SYNC_PPS_ERR_EN.
- Defined: adds output pps_err (1 bit, reset 0, sticky until clr).
  - Set when a rise arrives in RUN state, i.e. before all n_intervals intervals completed (early/extra pps).
  - Also set when state remains HOLD for more than len*2 clocks without a rise (missing pps). Uses a hold_timer of LEN_W+1 bits.
- Not defined: port and logic absent; behaviour otherwise identical.

Test Plan:
- Reset/idle: clr=1 for 3 cycles, then pps low for 100 cycles → Numb_inter=0, ev=0, cnt_clr=0, busy=0 throughout.
- Nominal:
  - Stimulus: len=20, n_int=3, period=4, ppi=3; pps rise at T.
  - Expected: cnt_clr at T+1, T+21, T+41; ev at T+2, T+6, T+10 (n_ch 0,1,0) and likewise per interval; Numb_inter 0,1,2.
  - Expected after: HOLD from T+61, with no further cnt_clr/ev.
- Overflowing strobes: len=10, period=4, ppi=5 → only 3 ev per interval (timer 1, 5, 9); pkt_idx resets at the next interval.
- Resync: with the nominal config, a second pps rise at T+30 → cnt_clr at T+31, Numb_inter=0, first ev at T+32 with n_ch=0. pps_err=1 if INTERVAL_SYNC_PPS_ERR_EN.
- Long pps and clr mid-run: pps held high for 50 cycles → one restart only; clr at T+15 → all outputs 0 next cycle, no ev until a new rise.
- Degenerate config: len=0, period=0, ppi=2, n_int=0 → treated as len=2, period=1, n_int=1; one cnt_clr, one ev at int_timer=1 with n_ch=0 (second strobe dropped), then HOLD.
